// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - 800x600@72 Hz raster constants and sprite defaults
// Contents: visible/porch/sync lengths, totals, sync start/end columns and
// lines, counter and position widths, square size, colours, sync polarity.
package vga_timing_pkg;

  localparam int H_VISIBLE = 800;
  localparam int H_FRONT   = 56;
  localparam int H_SYNC    = 120;
  localparam int H_BACK    = 64;
  localparam int V_VISIBLE = 600;
  localparam int V_FRONT   = 37;
  localparam int V_SYNC    = 6;
  localparam int V_BACK    = 23;

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;  // 1040
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;  // 666

  localparam int H_SYNC_START = H_VISIBLE + H_FRONT;                // 856
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;              // 976
  localparam int V_SYNC_START = V_VISIBLE + V_FRONT;                // 637
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;              // 643

  localparam int H_W = 11;  // horizontal counter width
  localparam int V_W = 10;  // vertical counter width
  localparam int X_W = 12;  // hor_pos width
  localparam int Y_W = 11;  // ver_pos width

  typedef logic [11:0] rgb_t;

  localparam int   SIZE       = 25;
  localparam rgb_t BALL_COLOR = 12'hFFF;
  localparam rgb_t BG_COLOR   = 12'h00F;
  localparam logic SYNC_POL   = 1'b1;

endpackage

// File: rtl/ball_renderer_if.sv
// rtl/ball_renderer_if.sv - position-in / VGA-out bundle of the ball renderer
// master: drives hor_pos/ver_pos, receives rgb/hsync/vsync/video_on/frame_tick.
// slave : the renderer side of the same signals.
interface ball_renderer_if;
  import vga_timing_pkg::*;

  logic [X_W-1:0] hor_pos;
  logic [Y_W-1:0] ver_pos;
  rgb_t           rgb;
  logic           hsync;
  logic           vsync;
  logic           video_on;
  logic           frame_tick;

  modport master (
    output hor_pos, ver_pos,
    input  rgb, hsync, vsync, video_on, frame_tick
  );

  modport slave (
    input  hor_pos, ver_pos,
    output rgb, hsync, vsync, video_on, frame_tick
  );

endinterface

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - raster counters with unregistered sync/visible/latch decode
// Ports: clock, reset (sync, active-high); h, v counters; hsync_act, vsync_act
// (active while in the sync window); visible (active area); latch_now
// (h == 0 on the first blanked line).
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_VISIBLE = vga_timing_pkg::H_VISIBLE,
  parameter int H_FRONT   = vga_timing_pkg::H_FRONT,
  parameter int H_SYNC    = vga_timing_pkg::H_SYNC,
  parameter int H_BACK    = vga_timing_pkg::H_BACK,
  parameter int V_VISIBLE = vga_timing_pkg::V_VISIBLE,
  parameter int V_FRONT   = vga_timing_pkg::V_FRONT,
  parameter int V_SYNC    = vga_timing_pkg::V_SYNC,
  parameter int V_BACK    = vga_timing_pkg::V_BACK
) (
  input  logic           clock,
  input  logic           reset,
  output logic [H_W-1:0] h,
  output logic [V_W-1:0] v,
  output logic           hsync_act,
  output logic           vsync_act,
  output logic           visible,
  output logic           latch_now
);

  localparam int HT  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int VT  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int HSS = H_VISIBLE + H_FRONT;
  localparam int HSE = HSS + H_SYNC;
  localparam int VSS = V_VISIBLE + V_FRONT;
  localparam int VSE = VSS + V_SYNC;

  always_ff @(posedge clock) begin
    if (reset) begin
      h <= '0;
      v <= '0;
    end else if (h == H_W'(HT - 1)) begin
      h <= '0;
      v <= (v == V_W'(VT - 1)) ? '0 : v + 1'b1;
    end else begin
      h <= h + 1'b1;
    end
  end

  // vsync is decoded from v alone, so it spans whole lines.
  assign hsync_act = (h >= H_W'(HSS)) && (h < H_W'(HSE));
  assign vsync_act = (v >= V_W'(VSS)) && (v < V_W'(VSE));
  assign visible   = (h < H_W'(H_VISIBLE)) && (v < V_W'(V_VISIBLE));
  assign latch_now = (h == '0) && (v == V_W'(V_VISIBLE));

endmodule

// File: rtl/ball_renderer.sv
// rtl/ball_renderer.sv - draws a SIZE x SIZE square over a flat background on VGA
// Ports: clock, reset (sync, active-high); bus (slave): hor_pos/ver_pos in,
// rgb/hsync/vsync/video_on/frame_tick out, all registered one cycle after
// the raster counter state they describe.
module ball_renderer
  import vga_timing_pkg::*;
#(
  parameter int   H_VISIBLE  = vga_timing_pkg::H_VISIBLE,
  parameter int   H_FRONT    = vga_timing_pkg::H_FRONT,
  parameter int   H_SYNC     = vga_timing_pkg::H_SYNC,
  parameter int   H_BACK     = vga_timing_pkg::H_BACK,
  parameter int   V_VISIBLE  = vga_timing_pkg::V_VISIBLE,
  parameter int   V_FRONT    = vga_timing_pkg::V_FRONT,
  parameter int   V_SYNC     = vga_timing_pkg::V_SYNC,
  parameter int   V_BACK     = vga_timing_pkg::V_BACK,
  parameter int   SIZE       = vga_timing_pkg::SIZE,
  parameter rgb_t BALL_COLOR = vga_timing_pkg::BALL_COLOR,
  parameter rgb_t BG_COLOR   = vga_timing_pkg::BG_COLOR,
  parameter logic SYNC_POL   = vga_timing_pkg::SYNC_POL
) (
  input  logic           clock,
  input  logic           reset,
  ball_renderer_if.slave bus
);

  // One extra bit so x+SIZE / y+SIZE never wrap back into low columns/lines.
  localparam int XS_W = X_W + 1;
  localparam int YS_W = Y_W + 1;

  logic [H_W-1:0] h;
  logic [V_W-1:0] v;
  logic           hsync_act;
  logic           vsync_act;
  logic           visible;
  logic           latch_now;

  logic [X_W-1:0] x;
  logic [Y_W-1:0] y;
  logic           inside_x;
  logic           inside_y;
  rgb_t           rgb_next;

  vga_timing_gen #(
    .H_VISIBLE (H_VISIBLE),
    .H_FRONT   (H_FRONT),
    .H_SYNC    (H_SYNC),
    .H_BACK    (H_BACK),
    .V_VISIBLE (V_VISIBLE),
    .V_FRONT   (V_FRONT),
    .V_SYNC    (V_SYNC),
    .V_BACK    (V_BACK)
  ) u_timing (
    .clock     (clock),
    .reset     (reset),
    .h         (h),
    .v         (v),
    .hsync_act (hsync_act),
    .vsync_act (vsync_act),
    .visible   (visible),
    .latch_now (latch_now)
  );

  always_comb begin
    inside_x = ({2'b00, h} >= {1'b0, x}) &&
               ({2'b00, h} <  ({1'b0, x} + XS_W'(SIZE)));
    inside_y = ({2'b00, v} >= {1'b0, y}) &&
               ({2'b00, v} <  ({1'b0, y} + YS_W'(SIZE)));
    rgb_next = 12'h000;
    if (visible) begin
      rgb_next = (inside_x && inside_y) ? BALL_COLOR : BG_COLOR;
    end
  end

  // The position is only sampled at the start of vertical blank, so the
  // square never tears within a drawn frame.
  always_ff @(posedge clock) begin
    if (reset) begin
      x              <= '0;
      y              <= '0;
      bus.rgb        <= 12'h000;
      bus.hsync      <= ~SYNC_POL;
      bus.vsync      <= ~SYNC_POL;
      bus.video_on   <= 1'b0;
      bus.frame_tick <= 1'b0;
    end else begin
      if (latch_now) begin
        x <= bus.hor_pos;
        y <= bus.ver_pos;
      end
      bus.rgb        <= rgb_next;
      bus.hsync      <= hsync_act ? SYNC_POL : ~SYNC_POL;
      bus.vsync      <= vsync_act ? SYNC_POL : ~SYNC_POL;
      bus.video_on   <= visible;
      bus.frame_tick <= latch_now;
    end
  end

endmodule

// File: tb/tb_ball_renderer.sv
// tb/tb_ball_renderer.sv - self-checking bench for ball_renderer on a reduced raster
module tb_ball_renderer;

  // Reduced raster keeps whole-frame scenarios within a short run.
  localparam int HV = 40, HF = 3, HS = 5, HB = 4;
  localparam int VV = 24, VF = 2, VS = 3, VB = 2;
  localparam int HT = HV + HF + HS + HB;   // 52
  localparam int VT = VV + VF + VS + VB;   // 31
  localparam int FRAME = HT * VT;          // 1612
  localparam int SZ = 6;
  localparam logic [11:0] BALL = 12'hFFF;
  localparam logic [11:0] BG   = 12'h00F;

  logic clock;
  logic reset;
  ball_renderer_if bus();

  ball_renderer #(
    .H_VISIBLE (HV), .H_FRONT (HF), .H_SYNC (HS), .H_BACK (HB),
    .V_VISIBLE (VV), .V_FRONT (VF), .V_SYNC (VS), .V_BACK (VB),
    .SIZE (SZ), .BALL_COLOR (BALL), .BG_COLOR (BG), .SYNC_POL (1'b1)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      if (n_bad <= 30)
        $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference model: raster position is just elapsed cycles modulo the frame.
  function automatic logic [11:0] f_rgb(int t, int x, int y);
    int h = t % HT;
    int v = t / HT;
    if (h >= HV || v >= VV) return 12'h000;
    if (h >= x && h < x + SZ && v >= y && v < y + SZ) return BALL;
    return BG;
  endfunction

  int          m_t = 0;
  int          m_x = 0;
  int          m_y = 0;
  bit          exp_valid = 1'b0;
  logic [11:0] exp_rgb;
  logic        exp_hs, exp_vs, exp_von, exp_tick;

  always @(posedge clock) begin
    if (reset) begin
      exp_valid <= 1'b1;
      exp_rgb   <= 12'h000;
      exp_hs    <= 1'b0;
      exp_vs    <= 1'b0;
      exp_von   <= 1'b0;
      exp_tick  <= 1'b0;
      m_t       <= 0;
      m_x       <= 0;
      m_y       <= 0;
    end else begin
      exp_rgb  <= f_rgb(m_t, m_x, m_y);
      exp_hs   <= (m_t % HT >= HV + HF) && (m_t % HT < HV + HF + HS);
      exp_vs   <= (m_t / HT >= VV + VF) && (m_t / HT < VV + VF + VS);
      exp_von  <= (m_t % HT < HV) && (m_t / HT < VV);
      exp_tick <= (m_t == VV * HT);
      if (m_t == VV * HT) begin
        m_x <= int'(bus.hor_pos);
        m_y <= int'(bus.ver_pos);
      end
      m_t <= (m_t + 1) % FRAME;
    end
  end

  always @(negedge clock) begin
    if (exp_valid) begin
      check("rgb",        32'(bus.rgb),        32'(exp_rgb));
      check("hsync",      32'(bus.hsync),      32'(exp_hs));
      check("vsync",      32'(bus.vsync),      32'(exp_vs));
      check("video_on",   32'(bus.video_on),   32'(exp_von));
      check("frame_tick", 32'(bus.frame_tick), 32'(exp_tick));
    end
  end

  // Waits for frame_tick, then observes one full frame starting at it and
  // checks literal totals. Optionally moves the inputs at line chg_line.
  task automatic measure_frame(input string tag, input int chg_line, input int nx, input int ny,
                               input int exp_lit, input int exp_fh, input int exp_fv);
    int n = 0;
    int lit = 0, fh = -1, fv = -1, hs = 0, vs = 0, von = 0, ticks = 0;
    int t, h, v;
    @(negedge clock);
    while (bus.frame_tick !== 1'b1 && n < 2 * FRAME) begin
      @(negedge clock);
      n++;
    end
    check({tag, "_tick_wait"}, 32'(bus.frame_tick), 32'd1);
    if (bus.frame_tick !== 1'b1) return;
    for (int k = 0; k < FRAME; k++) begin
      if (k > 0) @(negedge clock);
      t = (VV * HT + k) % FRAME;
      h = t % HT;
      v = t / HT;
      if (bus.rgb === BALL) begin
        if (lit == 0) begin fh = h; fv = v; end
        lit++;
      end
      if (bus.hsync === 1'b1) hs++;
      if (bus.vsync === 1'b1) vs++;
      if (bus.video_on === 1'b1) von++;
      if (bus.frame_tick === 1'b1) ticks++;
      if (chg_line >= 0 && v == chg_line && h == 0) begin
        bus.hor_pos = 12'(nx);
        bus.ver_pos = 11'(ny);
      end
    end
    check({tag, "_lit"},     32'(lit),   32'(exp_lit));
    check({tag, "_first_h"}, 32'(fh),    32'(exp_fh));
    check({tag, "_first_v"}, 32'(fv),    32'(exp_fv));
    check({tag, "_hs_cyc"},  32'(hs),    32'd155);
    check({tag, "_vs_cyc"},  32'(vs),    32'd156);
    check({tag, "_von_cyc"}, 32'(von),   32'd960);
    check({tag, "_ticks"},   32'(ticks), 32'd1);
  endtask

  initial begin
    int rst_at, rst_len, n, lit, fh, fv;
    reset = 1'b1;
    bus.hor_pos = '0;
    bus.ver_pos = '0;
    repeat (3) @(negedge clock);
    check("rst_rgb",      32'(bus.rgb),        32'h0);
    check("rst_hsync",    32'(bus.hsync),      32'h0);
    check("rst_vsync",    32'(bus.vsync),      32'h0);
    check("rst_video_on", 32'(bus.video_on),   32'h0);
    check("rst_tick",     32'(bus.frame_tick), 32'h0);
    reset = 1'b0;

    // Randomized phase: inputs change every cycle, plus one random reset.
    rst_at  = $urandom_range(FRAME, 4 * FRAME);
    rst_len = $urandom_range(1, 3);
    for (int i = 0; i < 5 * FRAME; i++) begin
      @(negedge clock);
      if ($urandom_range(0, 7) == 0) bus.hor_pos = 12'($urandom_range(4000, 4095));
      else                           bus.hor_pos = 12'($urandom_range(0, HV + SZ));
      bus.ver_pos = 11'($urandom_range(0, VV + SZ));
      if (i == rst_at) reset = 1'b1;
      if (i == rst_at + rst_len) reset = 1'b0;
    end
    reset = 1'b0;

    // Square fully inside, then a mid-frame input change.
    bus.hor_pos = 12'd10;
    bus.ver_pos = 11'd5;
    measure_frame("pos_10_5", -1, 0, 0, 36, 10, 5);
    measure_frame("no_tear", 12, 20, 12, 36, 10, 5);
    measure_frame("pos_20_12", -1, 0, 0, 36, 20, 12);

    // Mid-frame reset with (20,12) latched: square returns to (0,0).
    n = 0;
    @(negedge clock);
    while (bus.frame_tick !== 1'b1 && n < 2 * FRAME) begin
      @(negedge clock);
      n++;
    end
    check("rst_tick_wait", 32'(bus.frame_tick), 32'd1);
    repeat ((VT - VV + 12) * HT) @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    check("midrst_video_on", 32'(bus.video_on), 32'h0);
    check("midrst_rgb",      32'(bus.rgb),      32'h0);
    reset = 1'b0;
    lit = 0; fh = -1; fv = -1;
    for (int k = 0; k < VV * HT; k++) begin
      @(negedge clock);
      if (bus.rgb === BALL) begin
        if (lit == 0) begin fh = k % HT; fv = k / HT; end
        lit++;
      end
    end
    check("midrst_lit",     32'(lit), 32'd36);
    check("midrst_first_h", 32'(fh),  32'd0);
    check("midrst_first_v", 32'(fv),  32'd0);

    // Clipped at the right/bottom edge: 3 x 3 pixels, no wrap.
    bus.hor_pos = 12'd37;
    bus.ver_pos = 11'd21;
    measure_frame("clip", -1, 0, 0, 9, 37, 21);

    // Far off-screen column near the top of the 12-bit range.
    bus.hor_pos = 12'd4093;
    bus.ver_pos = 11'd0;
    measure_frame("offscreen", -1, 0, 0, 0, -1, -1);

    repeat (4) @(negedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ball_renderer.md
Name: ball_renderer

Overview:
- Reads the sprite position produced by the position/motion block and draws it on an 800x600 VGA display.
- Generates all raster timing (horizontal/vertical counters, hsync, vsync, blanking).
- Paints a SIZE x SIZE square at the latched position over a flat background.
- Sits between the position logic and the VGA pins; runs on the 50 MHz pixel clock (800x600@72 Hz).

Parameters:
- H_VISIBLE, 800, active pixels per line
- H_FRONT, 56, horizontal front porch (pixels)
- H_SYNC, 120, hsync width (pixels)
- H_BACK, 64, horizontal back porch (pixels)
- V_VISIBLE, 600, active lines per frame
- V_FRONT, 37, vertical front porch (lines)
- V_SYNC, 6, vsync width (lines)
- V_BACK, 23, vertical back porch (lines)
- SIZE, 25, square edge length (pixels)
- BALL_COLOR, 12'hFFF, square colour (4:4:4 RGB)
- BG_COLOR, 12'h00F, background colour in the visible area
- SYNC_POL, 1, active level of hsync/vsync

Ports:
- clock  in  1  pixel clock, 50 MHz
- reset  in  1  synchronous, active-high reset
- hor_pos  in  12  square left column, unsigned
- ver_pos  in  11  square top line, unsigned
- rgb  out  12  pixel colour {R[3:0],G[3:0],B[3:0]}
- hsync  out  1  horizontal sync, level SYNC_POL when active
- vsync  out  1  vertical sync, level SYNC_POL when active
- video_on  out  1  high while in the visible area
- frame_tick  out  1  one-cycle pulse when the position is latched

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high. All state updates only on posedge clock.
- Totals: H_TOTAL = 1040, V_TOTAL = 666.
- Horizontal counter h: counts 0..H_TOTAL-1, then wraps to 0.
- Vertical counter v: increments when h wraps; counts 0..V_TOTAL-1, then wraps to 0.
- Reset values:
  - h = 0, v = 0, latched x/y = 0.
  - rgb = 0, hsync = vsync = ~SYNC_POL, video_on = 0, frame_tick = 0.
- Latency: every output is registered. Counter state (h,v) in cycle n is reflected on all outputs in cycle n+1. All outputs stay mutually aligned.
- hsync active for h in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC), i.e. 856..975.
- vsync active for v in [V_VISIBLE+V_FRONT, V_VISIBLE+V_FRONT+V_SYNC), i.e. 637..642, for full lines.
- video_on = (h < H_VISIBLE) && (v < V_VISIBLE).
- Position latch:
  - At h == 0 and v == V_VISIBLE (start of vertical blank), latch x <= hor_pos and y <= ver_pos.
  - frame_tick goes high for exactly that one output cycle.
  - Inputs are ignored at all other times, so there is no tearing from mid-frame updates.
- Inside test: (h >= x) && (h < x+SIZE) && (v >= y) && (v < y+SIZE).
  - Sums are computed at 13 bits (x) and 12 bits (y), so there is no wrap-around.
- rgb = video_on ? (inside ? BALL_COLOR : BG_COLOR) : 12'h000.
- Clipping:
  - A square extending past column 799 or line 599 is clipped, not wrapped.
  - x >= 800 or y >= 600 gives no lit pixels.
- Reset mid-frame: counters restart at (0,0) on the next edge, outputs return to reset values, latched position returns to (0,0). After release the square is drawn at (0,0) until the next vertical-blank latch.
- Reset has priority over the latch when both occur in the same cycle.

Decomposition:
- Package vga_timing_pkg holds:
  - the timing constants above;
  - H_TOTAL, V_TOTAL;
  - derived sync start/end values;
  - counter widths (11 bits for h, 10 bits for v).
- One sub-module, vga_timing_gen: h/v counters, sync/video_on decode, latch strobe.
- ball_renderer instantiates it and adds the position latch, the inside test, and the colour mux/output registers.

Test Plan:
1. Reset held 3 cycles, then released:
   - During reset: rgb=0, hsync=vsync=0, video_on=0.
   - After release: hsync high pulses exactly 120 cycles wide with period 1040.
   - vsync high exactly 6240 cycles with period 692640.
2. hor_pos=100, ver_pos=50 held across a vblank:
   - In the next frame, rgb=12'hFFF exactly for h 100..124, v 50..74 (625 pixels).
   - Remaining visible pixels are 12'h00F; blanking pixels are 0.
   - frame_tick fires once per 692640 cycles.
3. Position changed to (200,300) at line 300 of a frame:
   - Current frame still draws at (100,50).
   - Following frame draws at 200..224 / 300..324.
4. hor_pos=790, ver_pos=590: exactly 100 lit pixels (h 790..799, v 590..599). Nothing appears at column 0 or line 0.
5. hor_pos=4090, ver_pos=0: zero lit pixels in the frame, no wrap into columns 0..18.
6. Reset asserted for 2 cycles at line 300 with position (200,300) latched:
   - Outputs go inactive; timing restarts at (0,0).
   - Square drawn at 0..24 / 0..24 until the next vblank latch picks up the inputs.
